clock_time_setter: RTL

Button-driven time-entry controller that writes a preset time into the alarm clock core. It captures the clock's current hours/minutes/seconds, lets the user edit each field with increment/decrement buttons, then delivers the edited preset through a request/acknowledge load handshake. It is the writer side of the clock's preset-load interface and sits between the front-panel button synchronisers and the clock core.

---
 rtl/clock_pkg.sv | 43 ++++
 rtl/clock_time_setter_if.sv | 23 ++
 rtl/btn_edge_repeat.sv | 48 ++++
 rtl/clock_time_setter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the alarm clock: time field sizing, the time-setter
// state encoding and the field_sel codes shown on the front panel.
package clock_pkg;

  localparam int DEF_FIELD_W       = 2;
  localparam int DEF_HOURS_MAX     = 3;
  localparam int DEF_MIN_MAX       = 3;
  localparam int DEF_SEC_MAX       = 3;
  localparam int DEF_REPEAT_CYCLES = 8;
  localparam int DEF_BLINK_CYCLES  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SET_H  = 3'd1,
    SET_M  = 3'd2,
    SET_S  = 3'd3,
    COMMIT = 3'd4
  } state_t;

  localparam logic [1:0] FSEL_NONE    = 2'd0;
  localparam logic [1:0] FSEL_HOURS   = 2'd1;
  localparam logic [1:0] FSEL_MINUTES = 2'd2;
  localparam logic [1:0] FSEL_SECONDS = 2'd3;

  // True while the user is editing one of the three fields.
  function automatic logic is_set_state(input state_t st);
    case (st)
      SET_H, SET_M, SET_S: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  // Which field the display should highlight in a given state.
  function automatic logic [1:0] fsel_of(input state_t st);
    case (st)
      SET_H:   return FSEL_HOURS;
      SET_M:   return FSEL_MINUTES;
      SET_S:   return FSEL_SECONDS;
      default: return FSEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/clock_time_setter_if.sv
// Preset-load channel between the time setter (writer) and the clock core.
// load_req stays high with stable preset_* until the core returns load_ack.
interface clock_time_setter_if #(
  parameter int FIELD_W = 2
) ();

  logic [FIELD_W-1:0] preset_hours;
  logic [FIELD_W-1:0] preset_minutes;
  logic [FIELD_W-1:0] preset_seconds;
  logic               load_req;
  logic               load_ack;

  modport master (
    output preset_hours, preset_minutes, preset_seconds, load_req,
    input  load_ack
  );

  modport slave (
    input  preset_hours, preset_minutes, preset_seconds, load_req,
    output load_ack
  );

endinterface

// File: rtl/btn_edge_repeat.sv
// Press/auto-repeat event generator for one debounced button. Emits a pulse
// in the cycle the button is first seen high, then one every REPEAT_CYCLES
// cycles while it stays held. A button already high when reset ends must be
// released once before it can produce events (armed_r).
module btn_edge_repeat #(
  parameter int REPEAT_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic evt
);

  localparam int CNT_W = $clog2(REPEAT_CYCLES + 1);

  logic             btn_q_r;
  logic             armed_r;
  logic [CNT_W-1:0] hold_cnt_r;
  logic             press_s;
  logic             rpt_s;

  // Event decode: rising edge, or the hold counter reaching a full period.
  always_comb begin
    press_s = btn & ~btn_q_r & armed_r;
    rpt_s   = btn & btn_q_r & armed_r & (hold_cnt_r == CNT_W'(REPEAT_CYCLES));
    evt     = press_s | rpt_s;
  end

  // Previous-level, arming and hold-length tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q_r    <= 1'b0;
      armed_r    <= 1'b0;
      hold_cnt_r <= CNT_W'(0);
    end else begin
      btn_q_r <= btn;
      armed_r <= armed_r | ~btn;
      if (!btn || !armed_r) begin
        hold_cnt_r <= CNT_W'(0);
      end else if (press_s || rpt_s) begin
        hold_cnt_r <= CNT_W'(1);
      end else begin
        hold_cnt_r <= hold_cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clock_time_setter.sv
// Front-panel time-entry controller: captures the live time, lets the user
// edit hours/minutes/seconds with inc/dec buttons and hands the result to
// the clock core over the preset-load handshake.
module clock_time_setter
  import clock_pkg::*;
#(
  parameter int FIELD_W       = DEF_FIELD_W,
  parameter int HOURS_MAX     = DEF_HOURS_MAX,
  parameter int MIN_MAX       = DEF_MIN_MAX,
  parameter int SEC_MAX       = DEF_SEC_MAX,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int BLINK_CYCLES  = DEF_BLINK_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode_btn,
  input  logic               inc_btn,
  input  logic               dec_btn,
  input  logic               cancel_btn,
  input  logic [FIELD_W-1:0] cur_hours,
  input  logic [FIELD_W-1:0] cur_minutes,
  input  logic [FIELD_W-1:0] cur_seconds,
  output logic               editing,
  output logic [1:0]         field_sel,
  output logic               blink,
  clock_time_setter_if.master load_if
);

  localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
  localparam logic [FIELD_W-1:0] H_MAX = FIELD_W'(HOURS_MAX);
  localparam logic [FIELD_W-1:0] M_MAX = FIELD_W'(MIN_MAX);
  localparam logic [FIELD_W-1:0] S_MAX = FIELD_W'(SEC_MAX);

  state_t               state_r;
  state_t               next_state_s;
  logic [FIELD_W-1:0]   hours_r, minutes_r, seconds_r;
  logic [FIELD_W-1:0]   hours_nxt_s, minutes_nxt_s, seconds_nxt_s;
  logic                 mode_q_r, mode_arm_r, cancel_q_r, cancel_arm_r;
  logic                 mode_press_s, cancel_press_s;
  logic                 inc_evt_s, dec_evt_s;
  logic                 load_req_r, editing_r, blink_r;
  logic [1:0]           field_sel_r;
  logic [BLINK_W-1:0]   blink_cnt_r;

  // Modulo (max+1) step; simultaneous inc and dec cancel out.
  function automatic logic [FIELD_W-1:0] field_step(
    input logic [FIELD_W-1:0] val,
    input logic [FIELD_W-1:0] max_v,
    input logic               up,
    input logic               down
  );
    logic [FIELD_W-1:0] res;
    if (up && !down) begin
      res = (val == max_v) ? FIELD_W'(0) : val + FIELD_W'(1);
    end else if (down && !up) begin
      res = (val == FIELD_W'(0)) ? max_v : val - FIELD_W'(1);
    end else begin
      res = val;
    end
    return res;
  endfunction

  btn_edge_repeat #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_inc (
    .clk   (clk),
    .reset (reset),
    .btn   (inc_btn),
    .evt   (inc_evt_s)
  );

  btn_edge_repeat #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_dec (
    .clk   (clk),
    .reset (reset),
    .btn   (dec_btn),
    .evt   (dec_evt_s)
  );

  // Mode/cancel previous levels and post-reset arming for plain edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q_r     <= 1'b0;
      mode_arm_r   <= 1'b0;
      cancel_q_r   <= 1'b0;
      cancel_arm_r <= 1'b0;
    end else begin
      mode_q_r     <= mode_btn;
      mode_arm_r   <= mode_arm_r | ~mode_btn;
      cancel_q_r   <= cancel_btn;
      cancel_arm_r <= cancel_arm_r | ~cancel_btn;
    end
  end

  // Press decode for mode and cancel.
  always_comb begin
    mode_press_s   = mode_btn & ~mode_q_r & mode_arm_r;
    cancel_press_s = cancel_btn & ~cancel_q_r & cancel_arm_r;
  end

  // Next state and next preset values; cancel beats mode beats inc/dec.
  always_comb begin
    next_state_s  = state_r;
    hours_nxt_s   = hours_r;
    minutes_nxt_s = minutes_r;
    seconds_nxt_s = seconds_r;
    case (state_r)
      IDLE: begin
        if (cancel_press_s) begin
          next_state_s = IDLE;
        end else if (mode_press_s) begin
          next_state_s  = SET_H;
          hours_nxt_s   = cur_hours;
          minutes_nxt_s = cur_minutes;
          seconds_nxt_s = cur_seconds;
        end else begin
          next_state_s = IDLE;
        end
      end
      SET_H: begin
        if (cancel_press_s) begin
          next_state_s = IDLE;
        end else if (mode_press_s) begin
          next_state_s = SET_M;
        end else begin
          hours_nxt_s = field_step(hours_r, H_MAX, inc_evt_s, dec_evt_s);
        end
      end
      SET_M: begin
        if (cancel_press_s) begin
          next_state_s = IDLE;
        end else if (mode_press_s) begin
          next_state_s = SET_S;
        end else begin
          minutes_nxt_s = field_step(minutes_r, M_MAX, inc_evt_s, dec_evt_s);
        end
      end
      SET_S: begin
        if (cancel_press_s) begin
          next_state_s = IDLE;
        end else if (mode_press_s) begin
          next_state_s = COMMIT;
        end else begin
          seconds_nxt_s = field_step(seconds_r, S_MAX, inc_evt_s, dec_evt_s);
        end
      end
      COMMIT: begin
        if (load_if.load_ack) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = COMMIT;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, preset and status registers; status is decoded from next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      hours_r     <= FIELD_W'(0);
      minutes_r   <= FIELD_W'(0);
      seconds_r   <= FIELD_W'(0);
      load_req_r  <= 1'b0;
      editing_r   <= 1'b0;
      field_sel_r <= FSEL_NONE;
    end else begin
      state_r     <= next_state_s;
      hours_r     <= hours_nxt_s;
      minutes_r   <= minutes_nxt_s;
      seconds_r   <= seconds_nxt_s;
      load_req_r  <= (next_state_s == COMMIT);
      editing_r   <= is_set_state(next_state_s);
      field_sel_r <= fsel_of(next_state_s);
    end
  end

  // Blink generator: restarts low on every state change, idle outside SET.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_r <= BLINK_W'(0);
      blink_r     <= 1'b0;
    end else if ((next_state_s != state_r) || !is_set_state(state_r)) begin
      blink_cnt_r <= BLINK_W'(0);
      blink_r     <= 1'b0;
    end else if (blink_cnt_r == BLINK_W'(BLINK_CYCLES - 1)) begin
      blink_cnt_r <= BLINK_W'(0);
      blink_r     <= ~blink_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
    end
  end

  assign load_if.preset_hours   = hours_r;
  assign load_if.preset_minutes = minutes_r;
  assign load_if.preset_seconds = seconds_r;
  assign load_if.load_req       = load_req_r;
  assign editing                = editing_r;
  assign field_sel              = field_sel_r;
  assign blink                  = blink_r;

endmodule
